lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// Data-side memory controller directly downstream of the ROB load/store port. Accepts one
// load (RN) or store (WN) at a time with size/sign from Inst_Name, serialises it onto the
// byte-wide RAM bus (little-endian), returns a sign/zero-extended word on Read_Value.
// Mem_Success is high while idle/done, low while busy. ROB capture is on its rising edge.
// PARAMETERS
// ADDR_W   32        address width of Addr and mem_a
// IO_BASE  32'h30000 addresses >= IO_BASE are the I/O region (UART at IO_BASE)
// PORTS
// clk          in   1   system clock
// rst          in   1   asynchronous, active-low reset
// rdy          in   1   global enable; low = freeze all state and outputs
// clr          in   1   ROB flush pulse (one cycle)
// RN           in   1   load request (level, held by ROB)
// WN           in   1   store request (level, held by ROB)
// Addr         in   32  byte address of access
// Wvalue       in   32  store data, low bytes used
// Inst_Name    in   17  opcode id, compared against `LB..`SW defines in constants.v
// Mem_Success  out  1   1 = idle/done, 0 = busy
// Read_Value   out  32  extended load result
// mem_din      in   8   RAM read byte, valid 1 cycle after mem_a
// mem_dout     out  8   RAM write byte
// mem_a        out  32  RAM byte address
// mem_wr       out  1   RAM write strobe
// io_buffer_full in 1   UART TX buffer full
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, Mem_Success=1, Read_Value=0, mem_a=0, mem_dout=0,
//   mem_wr=0, byte counter=0. rdy=0: nothing changes (counter, outputs held).
// - States: IDLE, READ, WRITE, HOLD. Size N: LB/LBU/SB=1, LH/LHU/SH=2, LW/LWU/SW=4.
// - IDLE: on posedge with WN=1 -> WRITE (WN wins if both); else RN=1 -> READ. Accept edge:
//   latch Addr/Wvalue/Inst_Name, Mem_Success<=0, mem_a<=Addr, byte k=0 driven.
// - READ: edge k (1..N-1): mem_a<=Addr+k, capture mem_din as byte k-1. Edge N: capture
//   byte N-1, Read_Value<=extended result, Mem_Success<=1, state->HOLD. Latency N edges.
//   LB/LH sign-extend from bit 7/15; LBU/LHU/LWU zero-extend; LW unchanged.
// - WRITE: accept edge mem_wr<=1, mem_dout<=Wvalue[7:0]; edge k: mem_a<=Addr+k,
//   mem_dout<=Wvalue[8k+7:8k]; edge N: mem_wr<=0, Mem_Success<=1, ->HOLD. Read_Value unchanged.
// - HOLD: one cycle, requests ignored (ROB re-drives RN/WN on the edge it first sees
//   Mem_Success=1; stale levels must not be re-accepted). Next edge -> IDLE.
// - Addr+k is 32-bit wrapping; no alignment check; no RAM access outside the N bytes.
// - clr=1 in READ: abort, mem_a unchanged, Read_Value unchanged, Mem_Success<=1, ->HOLD.
//   clr in WRITE ignored (stores reach here only at commit; must complete). clr in IDLE/HOLD:
//   no effect; clr on the same edge as an RN accept suppresses the accept.
// - mem_wr is never high outside WRITE; at most one access in flight.
// CONFIGURATION
// IO_BUFFER_STALL_EN defined: a store with Addr>=IO_BASE sampled in IDLE while
//   io_buffer_full=1 is not accepted (stay IDLE, Mem_Success=1) until io_buffer_full=0.
//   I/O reads (Addr>=IO_BASE) additionally wait one extra cycle before byte capture.
// Not defined: io_buffer_full ignored; I/O accesses timed exactly as RAM.
// TESTING
// - mem[0x200]=0x80, RN=1 LB Addr=0x200 -> 1 edge later Read_Value=0xFFFFFF80, Mem_Success 0->1.
// - mem[0x10..0x11]=0x34,0x92, LHU Addr=0x10 -> Read_Value=0x00009234 after 2 edges; LH -> 0xFFFF9234.
// - SW Addr=0x100 Wvalue=0x12345678 -> mem_wr=1 for 4 cycles, bytes 78,56,34,12 at
//   0x100..0x103, then mem_wr=0, Mem_Success=1; mem[0x104] untouched.
// - RN held high across completion and HOLD, then ROB swaps to SB -> exactly one load, then
//   one store; no duplicated access (count mem_a transactions).
// - LW in flight, clr at byte 2 -> Mem_Success=1 next edge, Read_Value keeps old value; SW
//   with clr mid-write still writes all 4 bytes.
// - rst=0 asserted mid-SW -> outputs at reset values immediately; with IO_BUFFER_STALL_EN,
//   SB to 0x30000 while io_buffer_full=1 stays unaccepted until it drops.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one load/store at a time, serialised little-endian onto a byte-wide RAM bus.
// Optional feature macro: IO_BUFFER_STALL_EN (UART back-pressure on I/O stores, extra I/O read wait).
`default_nettype none

`ifndef LB
`define LB  17'd1
`endif
`ifndef LH
`define LH  17'd2
`endif
`ifndef LW
`define LW  17'd3
`endif
`ifndef LBU
`define LBU 17'd4
`endif
`ifndef LHU
`define LHU 17'd5
`endif
`ifndef LWU
`define LWU 17'd6
`endif
`ifndef SB
`define SB  17'd7
`endif
`ifndef SH
`define SH  17'd8
`endif
`ifndef SW
`define SW  17'd9
`endif

module lsu_mem_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              RN,
  input  logic              WN,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Wvalue,
  input  logic [16:0]       Inst_Name,
  output logic              Mem_Success,
  output logic [31:0]       Read_Value,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_HOLD = 2'd3} state_t;

  function automatic logic [2:0] op_size(input logic [16:0] op);
    case (op)
      `LB, `LBU, `SB: op_size = 3'd1;
      `LH, `LHU, `SH: op_size = 3'd2;
      default:        op_size = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [16:0] op, input logic [31:0] w);
    case (op)
      `LB:     extend = {{24{w[7]}}, w[7:0]};
      `LH:     extend = {{16{w[15]}}, w[15:0]};
      `LBU:    extend = {24'd0, w[7:0]};
      `LHU:    extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [16:0]         op_q;
  logic [2:0]          cnt;
  logic [31:0]         rbuf;
  logic                io_wait;
  logic                accept_rd, accept_wr;
  logic                wr_stall, is_io;
  logic [2:0]          size_q;
  logic [1:0]          byte_sel;
  logic [31:0]         merged;
  logic [7:0]          wbyte;

`ifdef IO_BUFFER_STALL_EN
  assign is_io    = (Addr >= IO_BASE);
  assign wr_stall = io_buffer_full && is_io;
`else
  logic unused_io;
  assign is_io     = 1'b0;
  assign wr_stall  = 1'b0;
  assign unused_io = io_buffer_full ^ (Addr >= IO_BASE);
`endif

  assign size_q   = op_size(op_q);
  assign byte_sel = 2'(cnt - 3'd1);
  assign wbyte    = wdata_q[{cnt[1:0], 3'b000} +: 8];

  // Word being assembled: byte (cnt-1) arrives on mem_din this cycle.
  always_comb begin
    merged = rbuf;
    merged[{byte_sel, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_nx  = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    case (state)
      S_IDLE: begin
        if (WN) begin
          if (!wr_stall) begin
            accept_wr = 1'b1;
            state_nx  = S_WRITE;
          end
        end else if (RN && !clr) begin
          accept_rd = 1'b1;
          state_nx  = S_READ;
        end
      end
      S_READ:  if (clr || (!io_wait && cnt == size_q)) state_nx = S_HOLD;
      S_WRITE: if (cnt == size_q) state_nx = S_HOLD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= '0;
      cnt         <= 3'd0;
      rbuf        <= '0;
      io_wait     <= 1'b0;
      Mem_Success <= 1'b1;
      Read_Value  <= '0;
      mem_dout    <= '0;
      mem_a       <= '0;
      mem_wr      <= 1'b0;
    end else if (rdy) begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept_rd || accept_wr) begin
            addr_q      <= Addr;
            wdata_q     <= Wvalue;
            op_q        <= Inst_Name;
            mem_a       <= Addr;
            Mem_Success <= 1'b0;
            cnt         <= 3'd1;
            io_wait     <= accept_rd && is_io;
            if (accept_wr) begin
              mem_wr   <= 1'b1;
              mem_dout <= Wvalue[7:0];
            end
          end
        end
        S_READ: begin
          if (clr) begin
            Mem_Success <= 1'b1;
            cnt         <= 3'd0;
            io_wait     <= 1'b0;
          end else if (io_wait) begin
            io_wait <= 1'b0;
          end else begin
            rbuf <= merged;
            if (cnt == size_q) begin
              Read_Value  <= extend(op_q, merged);
              Mem_Success <= 1'b1;
              cnt         <= 3'd0;
            end else begin
              mem_a <= addr_q + ADDR_W'(cnt);
              cnt   <= cnt + 3'd1;
            end
          end
        end
        S_WRITE: begin
          // Stores arrive only at commit, so a flush never cuts one short.
          if (cnt == size_q) begin
            mem_wr      <= 1'b0;
            Mem_Success <= 1'b1;
            cnt         <= 3'd0;
          end else begin
            mem_a    <= addr_q + ADDR_W'(cnt);
            mem_dout <= wbyte;
            cnt      <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized load/store traffic against a byte-array RAM
// and a transaction-level reference model; IO_BUFFER_STALL_EN adds the UART stall case.
`default_nettype none

`ifndef LB
`define LB  17'd1
`endif
`ifndef LH
`define LH  17'd2
`endif
`ifndef LW
`define LW  17'd3
`endif
`ifndef LBU
`define LBU 17'd4
`endif
`ifndef LHU
`define LHU 17'd5
`endif
`ifndef LWU
`define LWU 17'd6
`endif
`ifndef SB
`define SB  17'd7
`endif
`ifndef SH
`define SH  17'd8
`endif
`ifndef SW
`define SW  17'd9
`endif

module tb_lsu_mem_ctrl;
  localparam logic [31:0] IO_BASE = 32'h30000;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, RN, WN;
  logic [31:0] Addr, Wvalue;
  logic [16:0] Inst_Name;
  logic        Mem_Success;
  logic [31:0] Read_Value;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  lsu_mem_ctrl #(.ADDR_W(32), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .RN(RN), .WN(WN), .Addr(Addr),
    .Wvalue(Wvalue), .Inst_Name(Inst_Name), .Mem_Success(Mem_Success),
    .Read_Value(Read_Value), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // RAM: combinational read of the current address, byte write on the clock edge
  logic [7:0]  ram [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a  = '0;
  logic [7:0]  pre_d  = '0;
  assign mem_din = ram[mem_a[11:0]];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (pre_we) ram[pre_a] = pre_d;
      else if (mem_wr) ram[mem_a[11:0]] = mem_dout;
    end
  end

  // Reference model: each access is a schedule indexed by edges since acceptance
  logic [7:0]  ref_mem [0:4095];
  int          m_phase;              // 0 idle, 1 busy, 2 hold
  bit          m_st;
  logic [31:0] m_addr, m_w;
  logic [16:0] m_op;
  int          m_n, m_j, m_extra;
  logic        e_succ, e_wr;
  logic [31:0] e_rv, e_a;
  logic [7:0]  e_dout;

  function automatic int tb_size(input logic [16:0] op);
    if (op == `LB || op == `LBU || op == `SB) return 1;
    if (op == `LH || op == `LHU || op == `SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] expect_load(input logic [16:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < tb_size(op); i++)
      v = v | (32'(ref_mem[12'(a + 32'(i))]) << (8 * i));
    if (op == `LB && v[7])  v = v | 32'hFFFF_FF00;
    if (op == `LH && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_j = 0; m_n = 0; m_extra = 0;
    e_succ = 1'b1; e_rv = '0; e_a = '0; e_wr = 1'b0; e_dout = '0;
  endtask

  task automatic model_start(input bit st);
    m_phase = 1; m_st = st; m_addr = Addr; m_w = Wvalue; m_op = Inst_Name;
    m_n = tb_size(Inst_Name); m_j = 0; m_extra = 0;
`ifdef IO_BUFFER_STALL_EN
    if (!st && Addr >= IO_BASE) m_extra = 1;
`endif
    e_a = Addr; e_succ = 1'b0;
    if (st) begin e_wr = 1'b1; e_dout = Wvalue[7:0]; end
  endtask

  task automatic model_step();
    bit stall;
    if (m_phase == 2) m_phase = 0;
    else if (m_phase == 0) begin
      stall = 1'b0;
`ifdef IO_BUFFER_STALL_EN
      stall = io_buffer_full && (Addr >= IO_BASE);
`endif
      if (WN) begin
        if (!stall) model_start(1'b1);
      end else if (RN && !clr) model_start(1'b0);
    end else begin
      m_j++;
      if (m_st) begin
        ref_mem[12'(m_addr + 32'(m_j - 1))] = 8'(m_w >> (8 * (m_j - 1)));
        if (m_j == m_n) begin e_wr = 1'b0; e_succ = 1'b1; m_phase = 2; end
        else begin e_a = m_addr + 32'(m_j); e_dout = 8'(m_w >> (8 * m_j)); end
      end else if (clr) begin
        e_succ = 1'b1; m_phase = 2;
      end else if (m_j - m_extra == m_n) begin
        e_rv = expect_load(m_op, m_addr); e_succ = 1'b1; m_phase = 2;
      end else if (m_j - m_extra > 0) begin
        e_a = m_addr + 32'(m_j - m_extra);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        if (pre_we) ref_mem[pre_a] = pre_d;
        if (rdy) model_step();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("Mem_Success", {31'd0, Mem_Success}, {31'd0, e_succ});
      check("Read_Value", Read_Value, e_rv);
      check("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
      check("mem_a", mem_a, e_a);
      check("mem_dout", {24'd0, mem_dout}, {24'd0, e_dout});
    end
  end

  // Acceptances (Mem_Success falling) and write-strobe cycles, as observed on the bus
  int   n_acc = 0;
  int   n_wr  = 0;
  logic ms_prev = 1'b1;
  always @(negedge clk) begin
    ms_prev <= Mem_Success;
    if (ms_prev && !Mem_Success) n_acc <= n_acc + 1;
    if (mem_wr) n_wr <= n_wr + 1;
  end

  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      rdy = rand_rdy ? (($urandom % 5) != 0) : 1'b1;
    end
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #2;
    pre_we = 1'b0;
  endtask

  // Waits for Mem_Success 1->0->1; lat = edges from acceptance to completion
  task automatic wait_txn(input int clr_at, output int lat);
    int n, acc;
    bit seen, done;
    n = 0; acc = 0; seen = 1'b0; done = 1'b0; lat = -1;
    while (!done && n < 100) begin
      @(posedge clk); #2;
      n++;
      if (!seen && !Mem_Success) begin seen = 1'b1; acc = n; end
      else if (seen && Mem_Success) begin done = 1'b1; lat = n - acc; end
      clr = !done && seen && clr_at > 0 && (n - acc) == clr_at;
    end
    clr = 1'b0;
    check("txn_completes", {31'd0, done}, 32'd1);
  endtask

  task automatic access(input bit st, input logic [31:0] a, input logic [31:0] w,
                        input logic [16:0] op, input int clr_at, output int lat);
    @(posedge clk); #2;
    RN = !st; WN = st; Addr = a; Wvalue = w; Inst_Name = op;
    wait_txn(clr_at, lat);
    RN = 1'b0; WN = 1'b0;
  endtask

  logic [16:0] lds [6] = '{`LB, `LH, `LW, `LBU, `LHU, `LWU};
  logic [16:0] sts [3] = '{`SB, `SH, `SW};

  initial begin
    int lat, a0, w0;
    bit st;
    logic [31:0] a;
    rst = 1'b0; clr = 1'b0; RN = 1'b0; WN = 1'b0; Addr = '0; Wvalue = '0;
    Inst_Name = '0; io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_success", {31'd0, Mem_Success}, 32'd1);
    check("reset_rv", Read_Value, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    poke(12'h200, 8'h80); poke(12'h010, 8'h34); poke(12'h011, 8'h92); poke(12'h104, 8'hA5);

    access(1'b0, 32'h200, 32'd0, `LB, 0, lat);
    check("lb_value", Read_Value, 32'hFFFF_FF80);
    check("lb_latency", lat, 32'd1);
    access(1'b0, 32'h10, 32'd0, `LHU, 0, lat);
    check("lhu_value", Read_Value, 32'h0000_9234);
    check("lhu_latency", lat, 32'd2);
    access(1'b0, 32'h10, 32'd0, `LH, 0, lat);
    check("lh_value", Read_Value, 32'hFFFF_9234);

    w0 = n_wr;
    access(1'b1, 32'h100, 32'h1234_5678, `SW, 0, lat);
    check("sw_latency", lat, 32'd4);
    check("sw_wr_cycles", n_wr - w0, 32'd4);
    check("sw_b0", {24'd0, ram[12'h100]}, 32'h78);
    check("sw_b1", {24'd0, ram[12'h101]}, 32'h56);
    check("sw_b2", {24'd0, ram[12'h102]}, 32'h34);
    check("sw_b3", {24'd0, ram[12'h103]}, 32'h12);
    check("sw_next_untouched", {24'd0, ram[12'h104]}, 32'hA5);
    check("sw_done_wr", {31'd0, mem_wr}, 32'd0);

    access(1'b0, 32'h40, 32'd0, `LW, 1, lat);
    check("lw_clr_latency", lat, 32'd2);
    check("lw_clr_rv_kept", Read_Value, 32'hFFFF_9234);
    access(1'b1, 32'h180, 32'hDEAD_BEEF, `SW, 2, lat);
    check("sw_clr_latency", lat, 32'd4);
    check("sw_clr_b0", {24'd0, ram[12'h180]}, 32'hEF);
    check("sw_clr_b3", {24'd0, ram[12'h183]}, 32'hDE);

    // RN stays high through completion and HOLD; ROB swaps to a store afterwards
    a0 = n_acc;
    @(posedge clk); #2;
    RN = 1'b1; WN = 1'b0; Addr = 32'h200; Inst_Name = `LB;
    wait_txn(0, lat);
    @(posedge clk); #2;
    RN = 1'b0; WN = 1'b1; Addr = 32'h204; Wvalue = 32'h5A; Inst_Name = `SB;
    wait_txn(0, lat);
    WN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("held_accepts", n_acc - a0, 32'd2);
    check("held_sb", {24'd0, ram[12'h204]}, 32'h5A);

    // Asynchronous reset in the middle of a word store
    @(posedge clk); #2;
    WN = 1'b1; Addr = 32'h300; Wvalue = 32'hCAFE_BABE; Inst_Name = `SW;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0; WN = 1'b0;
    #1;
    check("rst_mid_success", {31'd0, Mem_Success}, 32'd1);
    check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_a", mem_a, 32'd0);
    check("rst_mid_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mid_rv", Read_Value, 32'd0);
    check("rst_mid_b0", {24'd0, ram[12'h300]}, 32'hBE);
    check("rst_mid_b1", {24'd0, ram[12'h301]}, {24'd0, pat(32'h301)});
    @(posedge clk); #3;
    rst = 1'b1;

`ifdef IO_BUFFER_STALL_EN
    io_buffer_full = 1'b1;
    @(posedge clk); #2;
    WN = 1'b1; Addr = IO_BASE; Wvalue = 32'h41; Inst_Name = `SB;
    repeat (4) begin
      @(posedge clk); #2;
      check("stall_success", {31'd0, Mem_Success}, 32'd1);
    end
    io_buffer_full = 1'b0;
    wait_txn(0, lat);
    WN = 1'b0;
    check("stall_sb_latency", lat, 32'd1);
    check("stall_sb_byte", {24'd0, ram[12'h000]}, 32'h41);
`endif

    rand_rdy = 1'b1;
    for (int t = 0; t < 150; t++) begin
      st = ($urandom % 2) == 1;
      case ($urandom % 8)
        0:       a = 32'hFFFF_FFFC + ($urandom % 4);
        1:       a = IO_BASE + ($urandom % 8);
        default: a = $urandom % 4096;
      endcase
      access(st, a, $urandom, st ? sts[$urandom % 3] : lds[$urandom % 6],
             (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0, lat);
    end
    rand_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
